// File: rtl/xt_fetch_ctrl.sv
// xt_fetch_ctrl: streams num_tiles consecutive x_t tiles out of the input ROM,
// follows the ROM's fixed 2-cycle read latency with a valid/index tag pipe and
// buffers returned tiles in a small FIFO feeding a valid/ready output stream.
// Optional feature macro: XT_FETCH_PERF_EN enables the stall_cycles counter;
// when it is undefined stall_cycles is tied to zero.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing addresses under the FIFO credit limit
// DRAIN | all addresses issued, waiting for in-flight reads and the FIFO to empty
// DONE  | one-cycle done pulse, back to IDLE
module xt_fetch_ctrl #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 16,
    parameter int TILE_SIZE  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W:0]          num_tiles,
    output logic                     busy,
    output logic                     done,
    output logic                     rom_en,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic signed [DATA_W-1:0] rom_dout_vec [TILE_SIZE],
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_vec [TILE_SIZE],
    output logic                     out_last,
    output logic [ADDR_W-1:0]        out_idx,
    output logic [31:0]              stall_cycles
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    generate
        if (FIFO_DEPTH < 4) begin : g_depth_chk
            $error("xt_fetch_ctrl: FIFO_DEPTH must be at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     num_q;
    logic [ADDR_W:0]     issue_cnt;
    logic [ADDR_W-1:0]   addr_hold;

    logic [1:0]          tag_v;
    logic [ADDR_W-1:0]   tag_idx [2];

    logic signed [DATA_W-1:0] fifo_data [FIFO_DEPTH][TILE_SIZE];
    logic [ADDR_W-1:0]   fifo_idx  [FIFO_DEPTH];
    logic                fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr, wr_ptr;
    logic [CNT_W-1:0]    fifo_count;

    logic                issue, issue_last, flush, push, pop, push_last, drain_ok;
    logic [1:0]          inflight;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit check, issue decision and ROM / stream drive; a discarded capture is
    // cheaper than letting the ROM zero its output between issues.
    always_comb begin
        inflight   = {1'b0, tag_v[0]} + {1'b0, tag_v[1]};
        flush      = abort && (state == S_RUN || state == S_DRAIN);
        issue      = (state == S_RUN) && !abort &&
                     ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);
        issue_last = issue && (issue_cnt == num_q - 1'b1);
        rom_addr   = issue ? base_q + issue_cnt[ADDR_W-1:0] : addr_hold;
        rom_en     = (state == S_RUN) || (state == S_DRAIN && tag_v != 2'b00);
        out_valid  = (fifo_count != '0);
        pop        = out_valid && out_ready;
        push       = tag_v[1];
        push_last  = ({1'b0, tag_idx[1]} == num_q - 1'b1);
        drain_ok   = (tag_v == 2'b00) &&
                     (fifo_count == '0 || (fifo_count == CNT_W'(1) && pop));
        out_idx    = fifo_idx[rd_ptr];
        out_last   = out_valid && fifo_last[rd_ptr];
        for (int j = 0; j < TILE_SIZE; j++) out_vec[j] = fifo_data[rd_ptr][j];
    end

    // Sequencer FSM with registered busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            base_q    <= '0;
            num_q     <= '0;
            issue_cnt <= '0;
            addr_hold <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q    <= base_addr;
                        num_q     <= num_tiles;
                        issue_cnt <= '0;
                        if (num_tiles == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (issue) begin
                        issue_cnt <= issue_cnt + 1'b1;
                        addr_hold <= rom_addr;
                        if (issue_last) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (abort || drain_ok) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Tag pipe mirroring the ROM read latency; stage 1 marks valid return data.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            tag_v      <= 2'b00;
            tag_idx[0] <= '0;
            tag_idx[1] <= '0;
        end else begin
            tag_v      <= {tag_v[0], issue};
            tag_idx[0] <= issue_cnt[ADDR_W-1:0];
            tag_idx[1] <= tag_idx[0];
        end
    end

    // Return FIFO; storage is cleared on reset so the stream outputs read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_idx[i]  <= '0;
                fifo_last[i] <= 1'b0;
                for (int j = 0; j < TILE_SIZE; j++) fifo_data[i][j] <= '0;
            end
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                for (int j = 0; j < TILE_SIZE; j++) fifo_data[wr_ptr][j] <= rom_dout_vec[j];
                fifo_idx[wr_ptr]  <= tag_idx[1];
                fifo_last[wr_ptr] <= push_last;
                wr_ptr            <= next_ptr(wr_ptr);
            end
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (!push && pop) fifo_count <= fifo_count - 1'b1;
        end
    end

    // The credit rule must never let a push land on a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && fifo_count == CNT_W'(FIFO_DEPTH)));

`ifdef XT_FETCH_PERF_EN
    // Saturating count of cycles where a tile waits on the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (state == S_IDLE && start) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_xt_fetch_ctrl.sv
// Bench for xt_fetch_ctrl: directed jobs push expected tiles into a queue and a
// negedge monitor pops and compares every accepted tile.
module tb_xt_fetch_ctrl;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;
    localparam int TS     = 4;
    localparam int FD     = 4;

    logic                     clk = 1'b0;
    logic                     rst, start, abort, out_ready;
    logic [ADDR_W-1:0]        base_addr;
    logic [ADDR_W:0]          num_tiles;
    logic                     busy, done, rom_en, out_valid, out_last;
    logic [ADDR_W-1:0]        rom_addr, out_idx;
    logic signed [DATA_W-1:0] rom_dout_vec [TS];
    logic signed [DATA_W-1:0] out_vec [TS];
    logic [31:0]              stall_cycles;

    logic signed [DATA_W-1:0] rom_r1 [TS];
    logic signed [DATA_W-1:0] rom_r2 [TS];

    typedef struct {
        int idx;
        int addr;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rlo = -1;
    int   rhi = -1;
    int   fv;
    bit   stalled = 1'b0;
    logic signed [DATA_W-1:0] held_vec [TS];
    logic [ADDR_W-1:0]        held_idx;

    xt_fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TILE_SIZE(TS), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .base_addr(base_addr), .num_tiles(num_tiles),
        .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_dout_vec(rom_dout_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
        .out_last(out_last), .out_idx(out_idx), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // ROM model: element j of tile k is 4k+j, two-cycle latency, zero when disabled.
    always @(posedge clk) begin
        for (int j = 0; j < TS; j++) begin
            rom_r1[j] <= rom_en ? DATA_W'(4 * int'(rom_addr) + j) : '0;
            rom_r2[j] <= rom_r1[j];
        end
    end
    assign rom_dout_vec = rom_r2;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        out_ready = !(cyc >= rlo && cyc <= rhi);
    endtask

    task automatic start_job(input int b, input int n);
        base_addr = ADDR_W'(b);
        num_tiles = (ADDR_W + 1)'(n);
        start     = 1'b1;
        cyc       = 0;
        for (int i = 0; i < n; i++)
            exp_q.push_back('{idx: i, addr: (b + i) % 64, last: (i == n - 1)});
        step();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int exp_done, input string name, output int first_v);
        first_v = -1;
        while (!done && cyc < exp_done + 30) begin
            if (out_valid && first_v < 0) first_v = cyc;
            step();
        end
        chk({name, "_done_cycle"}, cyc, exp_done);
        chk({name, "_busy_at_done"}, busy, 0);
        step();
        chk({name, "_done_width"}, done, 0);
    endtask

    // Monitor: stability under backpressure and in-order tile comparison.
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_valid_hold", out_valid, 1);
                chk("stall_vec_hold", out_vec[0], held_vec[0]);
                chk("stall_idx_hold", out_idx, held_idx);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tile: got idx %0d expected no tile (cycle %0d)", out_idx, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("tile_idx", out_idx, mon_e.idx);
                    for (int j = 0; j < TS; j++)
                        chk("tile_vec", out_vec[j], 4 * mon_e.addr + j);
                    chk("tile_last", out_last, mon_e.last);
                end
            end
            stalled  = out_valid && !out_ready;
            held_vec = out_vec;
            held_idx = out_idx;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        base_addr = '0; num_tiles = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rom_en", rom_en, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_vec0", out_vec[0], 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_stall", stall_cycles, 0);
        step();

        // Basic job: base 5, 8 tiles
        start_job(5, 8);
        chk("basic_rom_en_c1", rom_en, 1);
        chk("basic_rom_addr_c1", rom_addr, 5);
        chk("basic_busy_c1", busy, 1);
        run_to_done(12, "basic", fv);
        chk("basic_first_valid", fv, 4);
        chk("basic_stall", stall_cycles, 0);
        step();

        // Address wrap: 62, 63, 0, 1
        start_job(62, 4);
        chk("wrap_addr_c1", rom_addr, 62);
        step();
        chk("wrap_addr_c2", rom_addr, 63);
        step();
        chk("wrap_addr_c3", rom_addr, 0);
        step();
        chk("wrap_addr_c4", rom_addr, 1);
        run_to_done(8, "wrap", fv);
        step();

        // Backpressure: out_ready low in cycles 4..13
        rlo = 4; rhi = 13;
        start_job(10, 8);
        while (cyc < 12) step();
        chk("bp_issue_limit_addr", rom_addr, 13);
        chk("bp_rom_en_run", rom_en, 1);
        chk("bp_valid_stalled", out_valid, 1);
        run_to_done(22, "bp", fv);
        rlo = -1; rhi = -1;
`ifdef XT_FETCH_PERF_EN
        chk("bp_stall_cycles", stall_cycles, 10);
`else
        chk("bp_stall_cycles", stall_cycles, 0);
`endif
        step();

        // Zero length
        start_job(7, 0);
        chk("zero_done_c1", done, 1);
        chk("zero_busy_c1", busy, 0);
        chk("zero_rom_en_c1", rom_en, 0);
        chk("zero_valid_c1", out_valid, 0);
        step();
        chk("zero_done_c2", done, 0);
        chk("zero_rom_en_c2", rom_en, 0);
        chk("zero_valid_c2", out_valid, 0);
        step();

        // Abort in cycle 6 of a 16-tile job
        start_job(20, 16);
        while (cyc < 6) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_done_c7", done, 1);
        chk("abort_valid_c7", out_valid, 0);
        chk("abort_busy_c7", busy, 0);
        chk("abort_rom_en_c7", rom_en, 0);
        chk("abort_tiles_left", exp_q.size(), 13);
        exp_q.delete();
        step();
        chk("abort_valid_c8", out_valid, 0);
        chk("abort_done_c8", done, 0);
        chk("abort_rom_en_c8", rom_en, 0);
        step();

        // Reset in cycle 6 of a 16-tile job
        start_job(30, 16);
        while (cyc < 6) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_rom_en", rom_en, 0);
        chk("mrst_rom_addr", rom_addr, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_vec0", out_vec[0], 0);
        chk("mrst_idx", out_idx, 0);
        chk("mrst_last", out_last, 0);
        chk("mrst_stall", stall_cycles, 0);
        chk("mrst_tiles_left", exp_q.size(), 14);
        exp_q.delete();
        step();

        // Fresh job after reset
        start_job(40, 5);
        run_to_done(9, "post_rst", fv);
        chk("post_rst_first_valid", fv, 4);
        step();

        // Full depth with stray start pulses while busy
        start_job(0, 64);
        while (!done && cyc < 120) begin
            if (cyc == 10 || cyc == 30) begin
                start = 1'b1; num_tiles = 7'd3; base_addr = 6'd50;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        chk("full_done_cycle", cyc, 68);
        step();
        chk("full_busy_after", busy, 0);
        chk("full_done_width", done, 0);
        repeat (3) step();
        chk("full_valid_idle", out_valid, 0);
        chk("full_rom_en_idle", rom_en, 0);
        chk("all_tiles_delivered", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/xt_fetch_ctrl.md
# xt_fetch_ctrl

Sequencer for the x_t input ROM. On `start` it streams `num_tiles` consecutive 4-element x_t tiles from `base_addr` and drives the ROM enable and address. It tracks the ROM's fixed 2-cycle read latency with an in-flight tag pipe and buffers returned tiles in a small FIFO. Tiles are presented to the downstream datapath on a valid/ready stream with a last-tile marker.

## Interface
- `ADDR_W`, 6: ROM address width; depth is 2^ADDR_W tiles.
- `DATA_W`, 16: signed element width.
- `TILE_SIZE`, 4: elements per tile.
- `FIFO_DEPTH`, 4: return-buffer entries; elaboration error if < 4.

- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: launch request; sampled only in IDLE.
- `abort`  in  1: flush the current job; sampled in RUN/DRAIN.
- `base_addr`  in  ADDR_W: first tile address; latched on accepted start.
- `num_tiles`  in  ADDR_W+1: tile count, 0..2^ADDR_W; latched on accepted start.
- `busy`  out  1: high in RUN and DRAIN.
- `done`  out  1: one-cycle pulse on job completion or abort.
- `rom_en`  out  1: ROM enable.
- `rom_addr`  out  ADDR_W: ROM address.
- `rom_dout_vec`  in  TILE_SIZE×DATA_W signed, unpacked: ROM read data.
- `out_valid`  out  1: tile available.
- `out_ready`  in  1: consumer accepts the tile.
- `out_vec`  out  TILE_SIZE×DATA_W signed, unpacked: tile data.
- `out_last`  out  1: qualifies the final tile of the job.
- `out_idx`  out  ADDR_W: tile index within the job (0-based).
- `stall_cycles`  out  32: backpressure counter (see Configuration).

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start` with `num_tiles` ≠ 0.
  - IDLE → DONE on `start` with `num_tiles` = 0.
  - RUN → DRAIN when the last address has been issued.
  - DRAIN → DONE when the in-flight count is 0, the FIFO is empty and the last handshake has completed.
  - DONE → IDLE unconditionally; `done` = 1 only in DONE.
- Issue rule: in RUN, a tile is issued when `fifo_count + inflight < FIFO_DEPTH`.
  - Issuing drives `rom_addr = (base_addr + issue_cnt) mod 2^ADDR_W` and increments `issue_cnt`.
  - When not issuing, `rom_addr` holds its value.
- `rom_en` is 1 throughout RUN, and in DRAIN while `inflight` ≠ 0; 0 otherwise.
  - It is held high on non-issue cycles because the ROM zeroes its output while disabled.
  - Captures on non-issue cycles are discarded via tags.
- In-flight pipe: 2-stage valid shift register. Stage 0 is loaded with the issue bit and shifts every cycle. `inflight` = popcount of the 2 stages.
  - On stage-1 valid, `rom_dout_vec` is written to the FIFO together with its index and a last flag (`idx == num_tiles-1`).
- FIFO: registered read. `out_valid` = FIFO not empty, and the head is presented on `out_*`.
  - A pop occurs on `out_valid && out_ready`.
  - A push and a pop in the same cycle are both performed.
  - The credit rule guarantees no overflow; an assertion checks for it in simulation.
- Address wrap: `base_addr + i` wraps modulo 2^ADDR_W. `num_tiles = 2^ADDR_W` reads every address exactly once.
- `abort` in RUN/DRAIN flushes the job:
  - next state DONE;
  - FIFO cleared;
  - tag pipe cleared;
  - `rom_en` 0;
  - `out_valid` 0 from the next cycle.
- `abort` in IDLE or DONE is ignored. `start` outside IDLE is ignored.
- Reset values: state IDLE; all outputs 0, including `rom_addr`, `out_vec`, `out_idx` and `stall_cycles`; FIFO and tag pipe empty.
- Reset mid-job behaves identically to reset from IDLE.

## Timing
- Cycle 0: `start` sampled. Cycle 1: state RUN, first address issued with `rom_en` = 1.
- Data for an address issued in cycle N is valid on `rom_dout_vec` in cycle N+2 and pushed at the end of N+2. `out_valid` rises in cycle N+3.
  - First tile: cycle 4 after `start`.
- Throughput: 1 tile/cycle with `out_ready` held high.
  - With `FIFO_DEPTH` = 4, steady state holds 1 buffered tile and 2 in flight.
- Job of T tiles with `out_ready` = 1:
  - last issue in cycle T;
  - last handshake in cycle T+3;
  - DONE (`done` = 1) in cycle T+4;
  - IDLE in T+5; `busy` low from T+4.
- `out_*` are stable while `out_valid && !out_ready`.

## Configuration
- `XT_FETCH_PERF_EN` defined: `stall_cycles` counts cycles with `out_valid && !out_ready`.
  - Saturates at 2^32-1.
  - Cleared on `rst` and on each accepted `start`.
- `XT_FETCH_PERF_EN` undefined: counter logic omitted and `stall_cycles` tied to 0.

## Test plan
- **Basic job:** preload ROM[k] = {4k+3, 4k+2, 4k+1, 4k}; `base_addr` = 5, `num_tiles` = 8, `out_ready` = 1.
  - 8 tiles in consecutive cycles 4..11, `out_idx` 0..7, `out_vec[0]` = 20..48 step 4;
  - `out_last` only on idx 7; `done` in cycle 12.
- **Wrap:** `base_addr` = 62, `num_tiles` = 4.
  - Addresses 62, 63, 0, 1 are issued; tile data matches those addresses.
- **Backpressure:** `out_ready` = 0 for cycles 4..13, then 1.
  - At most 4 issues before stall; no tile lost or duplicated; `out_vec` stable while stalled;
  - with `XT_FETCH_PERF_EN`, `stall_cycles` = 10.
- **Zero length:** `num_tiles` = 0.
  - `done` pulses in cycle 1; `rom_en` and `out_valid` stay 0.
- **Abort / reset mid-job:** `abort` in cycle 6 of a 16-tile job.
  - `done` in cycle 7; FIFO empty; `out_valid` 0 from cycle 7.
  - Repeat with `rst` at cycle 6: all outputs 0 in cycle 7.
  - A new job started afterwards delivers correct data.
- **Full depth:** `num_tiles` = 64, `base_addr` = 0.
  - All 64 addresses read once; `out_last` on idx 63.
  - `start` pulses while busy are ignored.
